// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out bit serializer with a one-word holding register.
// Feeds the serial pattern detector one bit per clock, gapless when fed.
module piso_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;

   logic             w_accept;
   logic             w_last;
   logic             w_out_bit;
   logic [WIDTH-1:0] w_shifted;

   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
         assign w_out_bit = r_sr[WIDTH-1];
      end else begin : g_lsb
         assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
         assign w_out_bit = r_sr[0];
      end
   endgenerate

   assign din_ready  = ~r_hold_full & rst;
   assign w_accept   = din_valid & din_ready;
   assign w_last     = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

   assign sout_valid = (r_state == ST_SHIFT);
   assign sout       = sout_valid ? w_out_bit : IDLE_BIT;
   assign word_start = sout_valid && (r_cnt == '0);
   assign busy       = sout_valid | r_hold_full;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_sr        <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sr    <= din;
                  r_cnt   <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_last) begin
                  // Held word wins; otherwise a same-cycle accept bypasses hold
                  if (r_hold_full) begin
                     r_sr        <= r_hold;
                     r_hold_full <= 1'b0;
                     r_cnt       <= '0;
                  end else if (w_accept) begin
                     r_sr  <= din;
                     r_cnt <= '0;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_sr  <= w_shifted;
                  r_cnt <= r_cnt + CW'(1);
                  if (w_accept) begin
                     r_hold      <= din;
                     r_hold_full <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
